// File: rtl/hack_pkg.sv
// Shared constants for the Hack ALU: control-bit positions, named operation encodings, arbiter states.
// Pure definitions; no logic, no latency, no flow control.
package hack_pkg;

    localparam int HACK_W = 16;

    // Control word layout is {zx,nx,zy,ny,f,no}, zx in the MSB
    localparam int ZX = 5;
    localparam int NX = 4;
    localparam int ZY = 3;
    localparam int NY = 2;
    localparam int F  = 1;
    localparam int NO = 0;

    localparam logic [5:0] ALU_ZERO      = 6'b101010;
    localparam logic [5:0] ALU_ONE       = 6'b111111;
    localparam logic [5:0] ALU_X_PLUS_Y  = 6'b000010;
    localparam logic [5:0] ALU_X_MINUS_Y = 6'b010011;
    localparam logic [5:0] ALU_X_AND_Y   = 6'b000000;
    localparam logic [5:0] ALU_NOT_X     = 6'b001101;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/hack_alu_arbiter_if.sv
// Request/response bundle between two requesters, the shared ALU arbiter and its consumer.
// master = requesters plus consumer side, slave = arbiter side.
interface hack_alu_arbiter_if
    import hack_pkg::*;
#(
    parameter int WIDTH = HACK_W,
    parameter int CNT_W = 16
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_x;
    logic [2*WIDTH-1:0] req_y;
    logic [11:0]        req_ctrl;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_out;
    logic               rsp_zr;
    logic               rsp_ng;
    logic [CNT_W-1:0]   op_count;

    modport master (
        output req_valid, req_x, req_y, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_zr, rsp_ng, op_count
    );

    modport slave (
        input  req_valid, req_x, req_y, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_out, rsp_zr, rsp_ng, op_count
    );
endinterface

// File: rtl/hack_alu.sv
// Combinational Hack ALU: x, y and six control bits to out plus zero/negative flags.
// Zero latency; no flow control.
module hack_alu
    import hack_pkg::*;
#(
    parameter int WIDTH = HACK_W
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);
    logic [WIDTH-1:0] xz, xn, yz, yn, r;

    always_comb begin
        xz  = ctrl[ZX] ? '0 : x;
        xn  = ctrl[NX] ? ~xz : xz;
        yz  = ctrl[ZY] ? '0 : y;
        yn  = ctrl[NY] ? ~yz : yz;
        // Carry out of the add is intentionally dropped
        r   = ctrl[F] ? (xn + yn) : (xn & yn);
        out = ctrl[NO] ? ~r : r;
    end

    assign zr = (out == '0);
    assign ng = out[WIDTH-1];

endmodule

// File: rtl/hack_alu_arbiter.sv
// Round-robin share of one Hack ALU between two requesters; result registered, 1 cycle accept->rsp_valid.
// Held result stalls new accepts until rsp_ready; with rsp_ready high it streams one op per cycle.
module hack_alu_arbiter
    import hack_pkg::*;
#(
    parameter int WIDTH = HACK_W,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    hack_alu_arbiter_if.slave bus
);
    state_t           state_q, state_d;
    logic             last_grant_q;
    logic             grant;
    logic             any_vld;
    logic             accept;
    logic             handshake;
    logic [WIDTH-1:0] x_sel, y_sel;
    logic [5:0]       ctrl_sel;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zr, alu_ng;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_out_q;
    logic             rsp_zr_q, rsp_ng_q;
    logic [CNT_W-1:0] op_count_q;

    // On a tie, the requester not served last time wins
    always_comb begin
        grant = 1'b0;
        case (bus.req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_q;
            default: grant = 1'b0;
        endcase
    end

    assign any_vld       = |bus.req_valid;
    assign accept        = ((state_q == IDLE) || bus.rsp_ready) && any_vld;
    assign handshake     = (state_q == HOLD) && bus.rsp_ready;
    assign bus.req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

    assign x_sel    = grant ? bus.req_x[2*WIDTH-1:WIDTH] : bus.req_x[WIDTH-1:0];
    assign y_sel    = grant ? bus.req_y[2*WIDTH-1:WIDTH] : bus.req_y[WIDTH-1:0];
    assign ctrl_sel = grant ? bus.req_ctrl[11:6]         : bus.req_ctrl[5:0];

    hack_alu #(.WIDTH(WIDTH)) u_alu (
        .x    (x_sel),
        .y    (y_sel),
        .ctrl (ctrl_sel),
        .out  (alu_out),
        .zr   (alu_zr),
        .ng   (alu_ng)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = HOLD;
            HOLD:    if (bus.rsp_ready && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            rsp_out_q    <= '0;
            rsp_zr_q     <= 1'b0;
            rsp_ng_q     <= 1'b0;
        end else if (accept) begin
            last_grant_q <= grant;
            rsp_id_q     <= grant;
            rsp_out_q    <= alu_out;
            rsp_zr_q     <= alu_zr;
            rsp_ng_q     <= alu_ng;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else if (handshake) begin
            op_count_q <= op_count_q + CNT_W'(1);
        end
    end

    assign bus.rsp_valid = (state_q == HOLD);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_zr    = rsp_zr_q;
    assign bus.rsp_ng    = rsp_ng_q;
    assign bus.op_count  = op_count_q;

endmodule

// File: doc/hack_alu_arbiter.md
Name: hack_alu_arbiter

Overview:
- Shares one combinational Hack ALU (x, y, six control bits zx/nx/zy/ny/f/no) between two requesters, e.g. the CPU execute path and a debug/DMA path.
- Arbitrates with round-robin priority and a valid/ready handshake on both the request and response sides.
- Registers the ALU result and flags, then returns them tagged with the requester ID.
- Counts completed operations for debug.

Parameters:
- WIDTH, 16, data width of x, y and out.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  2  bit i: requester i presents an operation.
- req_ready  out  2  bit i: operation i is accepted this cycle. One-hot or zero.
- req_x  in  2*WIDTH  x operand; requester i is in slice [i*WIDTH +: WIDTH].
- req_y  in  2*WIDTH  y operand; same slicing as req_x.
- req_ctrl  in  12  6-bit ALU control per requester, {zx,nx,zy,ny,f,no}; slice [i*6 +: 6].
- rsp_valid  out  1  result registered and available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  requester that issued the held result.
- rsp_out  out  WIDTH  ALU result.
- rsp_zr  out  1  rsp_out == 0.
- rsp_ng  out  1  rsp_out[WIDTH-1].
- op_count  out  CNT_W  number of completed response handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_zr=0, rsp_ng=0.
  - op_count=0, last_grant=1, so requester 0 wins the first tie.
- States:
  - IDLE: no result held.
  - HOLD: result held, rsp_valid=1.
- Grant (combinational):
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester != last_grant is granted.
- Accept condition: accept = (state==IDLE || rsp_ready) && any req_valid.
  - req_ready[g] = accept for the granted requester g; all other bits are 0.
  - req_ready may depend combinationally on rsp_ready and req_valid.
  - req_ready never depends on the data inputs.
- On the clock edge with accept:
  - rsp_out, rsp_zr, rsp_ng are loaded from the ALU evaluated on the granted slice.
  - rsp_id <= g, last_grant <= g, state <= HOLD.
- Latency: 1 cycle from accept to rsp_valid.
- Throughput: 1 operation per cycle when rsp_ready is held high (pass-through HOLD->HOLD).
- HOLD with rsp_ready=0:
  - All rsp_* outputs are stable.
  - req_ready=0.
  - Requests stay pending, and requesters must hold their data stable.
- HOLD with rsp_ready=1:
  - op_count increments.
  - If accept, a new result is loaded (stay in HOLD).
  - Otherwise go to IDLE with rsp_valid=0; data registers keep their last values.
- IDLE with no valid request: hold state; op_count is unchanged.
- ALU arithmetic:
  - x' = zx?0:x, then nx?~x':x'; y likewise with zy/ny.
  - r = f ? (x'+y') mod 2^WIDTH : x'&y'.
  - out = no ? ~r : r.
  - Carry out is discarded.
- Fairness: a requester holding valid is granted within at most 2 accepts.
- Reset mid-operation discards the held result; it is never delivered and never counted.
- op_count wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Shared package (hack_pkg) holds:
  - HACK_W=16.
  - Control-bit index constants ZX..NO.
  - Named 6-bit encodings: ALU_ZERO=101010, ALU_ONE=111111, ALU_X_PLUS_Y=000010, ALU_X_MINUS_Y=010011, ALU_X_AND_Y=000000, ALU_NOT_X=001101.
  - State encoding IDLE=0, HOLD=1.
- One sub-module: hack_alu, purely combinational (x, y, ctrl -> out, zr, ng).
  - Instantiated once on the muxed granted operands.
- The arbiter, FSM and counter stay in the top module.

Test Plan:
- Reset release, req0 valid, x=5, y=3, ctrl=000010, rsp_ready=1 -> req_ready=01 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_out=8, zr=0, ng=0; op_count=1 after the handshake.
- Both valid every cycle with rsp_ready=1: req0 x=5,y=3 ctrl=010011; req1 x=5,y=3 ctrl=000000 -> grants alternate 0,1,0,1; rsp_out sequence 2,1,2,1; one response per cycle.
- req1 valid x=5 ctrl=001101, rsp_ready=0 for 3 cycles -> rsp_out=0xFFFA, ng=1, zr=0, all held stable; req_ready=00 throughout, new req0 stays pending; rsp_ready=1 then accepts req0 that same cycle.
- ctrl=101010 with any x,y -> rsp_out=0, zr=1, ng=0; ctrl=111111 -> rsp_out=1.
- rst_n pulsed low asynchronously mid-HOLD -> rsp_valid=0 and op_count=0 immediately, before the next clock edge; the first grant after release goes to requester 0 when both are valid.
- Force op_count to 0xFFFF, complete one handshake -> op_count=0x0000.
